sram_arb: RTL and testbench

- Round-robin arbiter sharing one sram_top request port between NUM_REQ masters (e.g. sram_axi bridge, video scan-out, DMA).
- Registers the winning command into a one-entry output stage and drives sram_top.
- Keeps an in-order FIFO of requester IDs for issued reads, so each returned read word goes back to the requester that issued it.

---
 rtl/sram_pkg.sv | 37 +++
 rtl/sram_arb_idfifo.sv | 67 ++++++
 rtl/sram_arb.sv | 165 ++++++++++++++++
 tb/tb_sram_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared SRAM command definitions used by the arbiter and the AXI bridge.
// The packed command carries one word-addressed request towards sram_top.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int SRAM_BW = 2;

    typedef struct packed {
        logic               rd;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_BW-1:0] be;
        logic [SRAM_DW-1:0] wr_data;
    } sram_cmd_t;

    localparam sram_cmd_t SRAM_CMD_IDLE = '{
        rd      : 1'b0,
        addr    : 18'h0_0000,
        be      : 2'b00,
        wr_data : 16'h0000
    };

    function automatic sram_cmd_t cmd_pack(
        input logic               rd,
        input logic [SRAM_AW-1:0] addr,
        input logic [SRAM_BW-1:0] be,
        input logic [SRAM_DW-1:0] wr_data
    );
        sram_cmd_t cmd;
        cmd.rd      = rd;
        cmd.addr    = addr;
        cmd.be      = be;
        cmd.wr_data = wr_data;
        return cmd;
    endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// In-order FIFO of requester IDs for reads that reached sram_top.
// A pop that coincides with a push is honoured even when empty or full, leaving occupancy unchanged.
module sram_arb_idfifo #(
    parameter  int W     = 1,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == CW'(0));
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    assign w_pop  = i_pop & (~o_empty | i_push);
    assign w_push = i_push & (~o_full | w_pop);

    // Next occupancy from the effective push/pop pair.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Round-robin arbiter multiplexing NUM_REQ masters onto the single sram_top command port,
// routing each read return back to its issuer through an in-order ID FIFO.
module sram_arb
    import sram_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 1,
    parameter int RD_DEPTH = 4
) (
    input  logic                       a_clk,
    input  logic                       a_rst,
    input  logic [NUM_REQ-1:0]         m_req,
    output logic [NUM_REQ-1:0]         m_ready,
    input  logic [NUM_REQ-1:0]         m_rd,
    input  logic [NUM_REQ*SRAM_AW-1:0] m_addr,
    input  logic [NUM_REQ*SRAM_BW-1:0] m_be,
    input  logic [NUM_REQ*SRAM_DW-1:0] m_wr_data,
    output logic [NUM_REQ-1:0]         m_rd_data_vld,
    output logic [SRAM_DW-1:0]         m_rd_data,
    output logic                       sram_req,
    input  logic                       sram_ready,
    output logic                       sram_rd,
    output logic [SRAM_AW-1:0]         sram_addr,
    output logic [SRAM_BW-1:0]         sram_be,
    output logic [SRAM_DW-1:0]         sram_wr_data,
    input  logic                       sram_rd_data_vld,
    input  logic [SRAM_DW-1:0]         sram_rd_data,
    output logic                       rd_orphan
);

    localparam int CW = $clog2(RD_DEPTH + 1);

    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_REQ-1:0] elig,
        input logic [ID_W-1:0]    last
    );
        logic [ID_W:0] pick;
        int            idx;
        pick = {(ID_W+1){1'b0}};
        // Scan backwards so the closest index after 'last' is the one that sticks.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (elig[idx[ID_W-1:0]]) begin
                pick = {1'b1, idx[ID_W-1:0]};
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    sram_cmd_t         w_cmd [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic [ID_W:0]      w_pick;
    logic [ID_W-1:0]    w_win;
    logic               w_grant;
    logic               w_free;
    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic               w_credit;
    logic [CW:0]        w_inflight;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [CW-1:0]      w_fifo_count;
    logic [ID_W-1:0]    w_fifo_head;

    logic               r_arb_en;
    logic               r_vld;
    sram_cmd_t          r_cmd;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_last;
    logic               r_orphan;

    assign w_free = ~r_vld | sram_ready;
    assign w_xfer = r_vld & sram_ready;
    assign w_push = w_xfer & r_cmd.rd;
    assign w_pop  = sram_rd_data_vld & ~w_fifo_empty;

    // Reads already committed: in the FIFO plus the one parked in the stage, less today's return.
    assign w_inflight = {1'b0, w_fifo_count} + (CW+1)'(r_vld & r_cmd.rd) - (CW+1)'(w_pop);
    assign w_credit   = (w_inflight < (CW+1)'(RD_DEPTH));

    // Unpack requester payloads and qualify reads against available credit.
    always_comb begin
        w_elig = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cmd[i]  = cmd_pack(m_rd[i],
                                 m_addr[SRAM_AW*i +: SRAM_AW],
                                 m_be[SRAM_BW*i +: SRAM_BW],
                                 m_wr_data[SRAM_DW*i +: SRAM_DW]);
            w_elig[i] = m_req[i] & (~m_rd[i] | w_credit);
        end
    end

    assign w_pick  = rr_pick(w_elig, r_last);
    assign w_win   = w_pick[ID_W-1:0];
    assign w_grant = r_arb_en & w_free & w_pick[ID_W];
    assign m_ready = w_grant ? onehot(w_win) : {NUM_REQ{1'b0}};

    // Grant enable: keeps m_ready low while reset is applied.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            r_arb_en <= 1'b0;
        end else begin
            r_arb_en <= 1'b1;
        end
    end

    // One-entry output stage and round-robin pointer.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            r_vld  <= 1'b0;
            r_cmd  <= SRAM_CMD_IDLE;
            r_id   <= {ID_W{1'b0}};
            r_last <= ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_vld  <= 1'b1;
            r_cmd  <= w_cmd[w_win];
            r_id   <= w_win;
            r_last <= w_win;
        end else if (w_xfer) begin
            r_vld  <= 1'b0;
        end
    end

    // Sticky flag for a return strobe with nothing outstanding.
    always_ff @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            r_orphan <= 1'b0;
        end else if (sram_rd_data_vld & w_fifo_empty & ~w_push) begin
            r_orphan <= 1'b1;
        end
    end

    sram_arb_idfifo #(
        .W     (ID_W),
        .DEPTH (RD_DEPTH)
    ) u_idfifo (
        .clk         (a_clk),
        .rst_n       (a_rst),
        .i_push      (w_push),
        .i_push_data (r_id),
        .i_pop       (sram_rd_data_vld),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign sram_req      = r_vld;
    assign sram_rd       = r_cmd.rd;
    assign sram_addr     = r_cmd.addr;
    assign sram_be       = r_cmd.be;
    assign sram_wr_data  = r_cmd.wr_data;
    assign rd_orphan     = r_orphan;
    assign m_rd_data     = sram_rd_data;
    assign m_rd_data_vld = onehot(w_fifo_head) & {NUM_REQ{w_pop}};

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: a tiny SRAM model echoes the read address as data,
// and every step compares outputs against hand-derived values.
module tb_sram_arb;

    logic        a_clk = 1'b0;
    logic        a_rst;
    logic [1:0]  m_req;
    logic [1:0]  m_ready;
    logic [1:0]  m_rd;
    logic [35:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wr_data;
    logic [1:0]  m_rd_data_vld;
    logic [15:0] m_rd_data;
    logic        sram_req;
    logic        sram_ready;
    logic        sram_rd;
    logic [17:0] sram_addr;
    logic [1:0]  sram_be;
    logic [15:0] sram_wr_data;
    logic        sram_rd_data_vld;
    logic [15:0] sram_rd_data;
    logic        rd_orphan;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [17:0] issued[$];

    sram_arb #(
        .NUM_REQ  (2),
        .ID_W     (1),
        .RD_DEPTH (4)
    ) dut (
        .a_clk            (a_clk),
        .a_rst            (a_rst),
        .m_req            (m_req),
        .m_ready          (m_ready),
        .m_rd             (m_rd),
        .m_addr           (m_addr),
        .m_be             (m_be),
        .m_wr_data        (m_wr_data),
        .m_rd_data_vld    (m_rd_data_vld),
        .m_rd_data        (m_rd_data),
        .sram_req         (sram_req),
        .sram_ready       (sram_ready),
        .sram_rd          (sram_rd),
        .sram_addr        (sram_addr),
        .sram_be          (sram_be),
        .sram_wr_data     (sram_wr_data),
        .sram_rd_data_vld (sram_rd_data_vld),
        .sram_rd_data     (sram_rd_data),
        .rd_orphan        (rd_orphan)
    );

    always #5 a_clk = ~a_clk;

    // SRAM model: remember addresses of reads accepted by sram_top.
    always @(posedge a_clk or negedge a_rst) begin
        if (!a_rst) begin
            issued.delete();
        end else if (sram_req && sram_ready && sram_rd) begin
            issued.push_back(sram_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic rd, input logic [17:0] a,
                           input logic [1:0] be, input logic [15:0] d);
        m_req[i]               = v;
        m_rd[i]                = rd;
        m_addr[18*i +: 18]     = a;
        m_be[2*i +: 2]         = be;
        m_wr_data[16*i +: 16]  = d;
    endtask

    task automatic ret_on();
        logic [17:0] a;
        a = 18'h0_0000;
        if (issued.size() > 0) a = issued.pop_front();
        sram_rd_data_vld = 1'b1;
        sram_rd_data     = a[15:0];
    endtask

    task automatic ret_off();
        sram_rd_data_vld = 1'b0;
        sram_rd_data     = 16'h0000;
    endtask

    initial begin
        a_rst = 1'b0;
        m_req = 2'b00; m_rd = 2'b00; m_addr = 36'h0; m_be = 4'h0; m_wr_data = 32'h0;
        sram_ready = 1'b1;
        ret_off();
        tick(); tick(); settle();
        chk("rst_sram_req", {31'h0, sram_req}, 32'h0);
        chk("rst_m_ready", {30'h0, m_ready}, 32'h0);
        chk("rst_orphan", {31'h0, rd_orphan}, 32'h0);
        chk("rst_rd_vld", {30'h0, m_rd_data_vld}, 32'h0);
        chk("rst_addr", {14'h0, sram_addr}, 32'h0);
        a_rst = 1'b1;
        tick();

        // 1: single read from requester 0
        set_req(0, 1'b1, 1'b1, 18'h0_0012, 2'b11, 16'h0000); settle();
        chk("t1_ready", {30'h0, m_ready}, 32'h1);
        tick(); set_req(0, 1'b0, 1'b1, 18'h0_0012, 2'b11, 16'h0000); settle();
        chk("t1_ready_drop", {30'h0, m_ready}, 32'h0);
        chk("t1_sram_req", {31'h0, sram_req}, 32'h1);
        chk("t1_addr", {14'h0, sram_addr}, 32'h12);
        chk("t1_rd", {31'h0, sram_rd}, 32'h1);
        tick(); settle();
        chk("t1_idle", {31'h0, sram_req}, 32'h0);
        ret_on(); settle();
        chk("t1_ret_vld", {30'h0, m_rd_data_vld}, 32'h1);
        chk("t1_ret_data", {16'h0, m_rd_data}, 32'h0012);
        tick(); ret_off(); settle();
        chk("t1_ret_off", {30'h0, m_rd_data_vld}, 32'h0);

        // 2: both requesters stream reads; last winner was 0, so 1 goes first
        set_req(0, 1'b1, 1'b1, 18'h0_0100, 2'b11, 16'h0000);
        set_req(1, 1'b1, 1'b1, 18'h0_0200, 2'b11, 16'h0000); settle();
        chk("t2_g0", {30'h0, m_ready}, 32'h2);
        tick(); set_req(1, 1'b1, 1'b1, 18'h0_0201, 2'b11, 16'h0000); settle();
        chk("t2_g1", {30'h0, m_ready}, 32'h1);
        chk("t2_addr_a", {14'h0, sram_addr}, 32'h200);
        tick(); set_req(0, 1'b1, 1'b1, 18'h0_0101, 2'b11, 16'h0000); settle();
        chk("t2_g2", {30'h0, m_ready}, 32'h2);
        chk("t2_addr_b", {14'h0, sram_addr}, 32'h100);
        tick(); set_req(1, 1'b0, 1'b1, 18'h0_0202, 2'b11, 16'h0000); ret_on(); settle();
        chk("t2_g3", {30'h0, m_ready}, 32'h1);
        chk("t2_ret0_vld", {30'h0, m_rd_data_vld}, 32'h2);
        chk("t2_ret0_data", {16'h0, m_rd_data}, 32'h0200);
        tick(); set_req(0, 1'b0, 1'b1, 18'h0_0102, 2'b11, 16'h0000); ret_on(); settle();
        chk("t2_ret1_vld", {30'h0, m_rd_data_vld}, 32'h1);
        chk("t2_ret1_data", {16'h0, m_rd_data}, 32'h0100);
        chk("t2_addr_d", {14'h0, sram_addr}, 32'h101);
        tick(); ret_on(); settle();
        chk("t2_ret2_vld", {30'h0, m_rd_data_vld}, 32'h2);
        chk("t2_ret2_data", {16'h0, m_rd_data}, 32'h0201);
        tick(); ret_on(); settle();
        chk("t2_ret3_vld", {30'h0, m_rd_data_vld}, 32'h1);
        chk("t2_ret3_data", {16'h0, m_rd_data}, 32'h0101);
        tick(); ret_off(); settle();
        chk("t2_idle", {31'h0, sram_req}, 32'h0);

        // 3: downstream stall holds the payload and blocks further grants
        set_req(0, 1'b1, 1'b0, 18'h0_0055, 2'b01, 16'h5555);
        set_req(1, 1'b1, 1'b0, 18'h0_0066, 2'b11, 16'h6666); settle();
        chk("t3_grant", {30'h0, m_ready}, 32'h2);
        tick(); set_req(1, 1'b0, 1'b0, 18'h0_0066, 2'b11, 16'h6666); sram_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t3_stall_ready", {30'h0, m_ready}, 32'h0);
            chk("t3_stall_req", {31'h0, sram_req}, 32'h1);
            chk("t3_stall_addr", {14'h0, sram_addr}, 32'h66);
            chk("t3_stall_data", {16'h0, sram_wr_data}, 32'h6666);
            tick();
        end
        sram_ready = 1'b1; settle();
        chk("t3_release", {30'h0, m_ready}, 32'h1);
        tick(); set_req(0, 1'b0, 1'b0, 18'h0_0055, 2'b01, 16'h5555); settle();
        chk("t3_next_addr", {14'h0, sram_addr}, 32'h55);
        chk("t3_next_be", {30'h0, sram_be}, 32'h1);
        tick(); settle();
        chk("t3_idle", {31'h0, sram_req}, 32'h0);

        // 5: boundary write on requester 1
        set_req(1, 1'b1, 1'b0, 18'h3_FFFF, 2'b10, 16'hAB03); settle();
        chk("t5_grant", {30'h0, m_ready}, 32'h2);
        tick(); set_req(1, 1'b0, 1'b0, 18'h3_FFFF, 2'b10, 16'hAB03); settle();
        chk("t5_rd", {31'h0, sram_rd}, 32'h0);
        chk("t5_addr", {14'h0, sram_addr}, 32'h3FFFF);
        chk("t5_be", {30'h0, sram_be}, 32'h2);
        chk("t5_data", {16'h0, sram_wr_data}, 32'hAB03);
        chk("t5_no_ret", {30'h0, m_rd_data_vld}, 32'h0);
        tick();

        // 4: read credit exhaustion with late returns
        set_req(0, 1'b1, 1'b1, 18'h0_0400, 2'b11, 16'h0000); settle();
        chk("t4_g0", {30'h0, m_ready}, 32'h1);
        for (int g = 1; g < 4; g++) begin
            tick(); set_req(0, 1'b1, 1'b1, 18'h0_0400 + 18'(g), 2'b11, 16'h0000); settle();
            chk("t4_g", {30'h0, m_ready}, 32'h1);
        end
        tick();
        set_req(0, 1'b1, 1'b1, 18'h0_0404, 2'b11, 16'h0000);
        set_req(1, 1'b1, 1'b0, 18'h0_0077, 2'b11, 16'h7777); settle();
        chk("t4_blocked_wr_ok", {30'h0, m_ready}, 32'h2);
        tick(); set_req(1, 1'b0, 1'b0, 18'h0_0077, 2'b11, 16'h7777); settle();
        chk("t4_still_blocked", {30'h0, m_ready}, 32'h0);
        chk("t4_wr_rd", {31'h0, sram_rd}, 32'h0);
        chk("t4_wr_addr", {14'h0, sram_addr}, 32'h77);
        tick(); settle();
        chk("t4_full_ready", {30'h0, m_ready}, 32'h0);
        chk("t4_full_idle", {31'h0, sram_req}, 32'h0);
        ret_on(); settle();
        chk("t4_ret0_vld", {30'h0, m_rd_data_vld}, 32'h1);
        chk("t4_ret0_data", {16'h0, m_rd_data}, 32'h0400);
        chk("t4_credit_back", {30'h0, m_ready}, 32'h1);
        tick(); set_req(0, 1'b0, 1'b1, 18'h0_0404, 2'b11, 16'h0000); ret_off(); settle();
        chk("t4_addr5", {14'h0, sram_addr}, 32'h404);
        for (int k = 1; k <= 4; k++) begin
            tick(); ret_on(); settle();
            chk("t4_drain_vld", {30'h0, m_rd_data_vld}, 32'h1);
            chk("t4_drain_data", {16'h0, m_rd_data}, 32'h0400 + k);
        end
        tick(); ret_off(); settle();

        // 6: orphan return, then reset in the middle of a burst
        chk("t6_orphan_pre", {31'h0, rd_orphan}, 32'h0);
        ret_on(); sram_rd_data = 16'hDEAD; settle();
        chk("t6_orphan_vld", {30'h0, m_rd_data_vld}, 32'h0);
        tick(); ret_off(); settle();
        chk("t6_orphan_flag", {31'h0, rd_orphan}, 32'h1);
        set_req(0, 1'b1, 1'b1, 18'h0_0500, 2'b11, 16'h0000); settle();
        chk("t6_burst_g0", {30'h0, m_ready}, 32'h1);
        tick(); set_req(0, 1'b1, 1'b1, 18'h0_0501, 2'b11, 16'h0000);
        tick();
        #2 a_rst = 1'b0;
        #1;
        chk("t6_rst_req", {31'h0, sram_req}, 32'h0);
        chk("t6_rst_ready", {30'h0, m_ready}, 32'h0);
        chk("t6_rst_orphan", {31'h0, rd_orphan}, 32'h0);
        chk("t6_rst_addr", {14'h0, sram_addr}, 32'h0);
        chk("t6_rst_rd", {31'h0, sram_rd}, 32'h0);
        chk("t6_rst_vld", {30'h0, m_rd_data_vld}, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
